// File: rtl/pwm_duty_controller.sv
// -----------------------------------------------------------------------------
// pwm_duty_controller
//
// Purpose
//   Front-end sequencer for a bank of duty-cycle modifier channels. It
//   synchronises and debounces three raw push-buttons. Button presses become
//   single-cycle up/down strobes for the currently selected channel. A one-hot
//   chip_select picks the channel, and a 4-bit shadow of each channel's duty
//   step is kept here.
//
// Optional feature
//   AUTO_REPEAT_EN : when defined, holding the issuing button re-issues the
//                    strobe every REPEAT_CYCLES cycles. When undefined, each
//                    press gives exactly one strobe and no repeat counter exists.
//
// Ports
//   clk_100MHz   in   1       system clock, rising edge
//   rst          in   1       synchronous reset, active-high
//   btn_up       in   1       raw button, increase duty
//   btn_down     in   1       raw button, decrease duty
//   btn_ch       in   1       raw button, advance to the next channel
//   up           out  1       one-cycle increase strobe to the selected channel
//   down         out  1       one-cycle decrease strobe to the selected channel
//   chip_select  out  NUM_CH  one-hot select of the current channel
//   ch_idx       out  CH_W    binary index of the current channel
//   duty_shadow  out  4       shadow duty step of the current channel
//   busy         out  1       high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module pwm_duty_controller #(
    parameter int NUM_CH        = 2,
    parameter int DEB_CYCLES    = 1000000,
    parameter int DUTY_MIN      = 0,
    parameter int DUTY_MAX      = 10,
    parameter int DUTY_RST      = 5,
    parameter int REPEAT_CYCLES = 25000000,
    localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_100MHz,
    input  logic              rst,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic              btn_ch,
    output logic              up,
    output logic              down,
    output logic [NUM_CH-1:0] chip_select,
    output logic [CH_W-1:0]   ch_idx,
    output logic [3:0]        duty_shadow,
    output logic              busy
);

    localparam int DEB_W = $clog2(DEB_CYCLES + 1);

    // Button vector ordering used throughout: [0]=up, [1]=down, [2]=ch.
    localparam int B_UP = 0;
    localparam int B_DN = 1;
    localparam int B_CH = 2;

    // Reject configurations the saturating 4-bit datapath cannot honour.
    if (NUM_CH < 2 || NUM_CH > 8 || DEB_CYCLES < 1 || REPEAT_CYCLES < 1 ||
        DUTY_MAX > 15 || DUTY_MIN < 0 || DUTY_MAX <= DUTY_MIN ||
        DUTY_RST < DUTY_MIN || DUTY_RST > DUTY_MAX) begin : g_bad_cfg
        $error("pwm_duty_controller: illegal parameter set");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_HOLD  = 2'b10
    } state_t;

    logic [2:0]                   raw_s;
    logic [2:0]                   sync1_q;
    logic [2:0]                   sync2_q;
    logic [2:0]                   stable_q;
    logic [2:0]                   stable_d;
    logic [2:0]                   stable_prev_q;
    logic [2:0][DEB_W-1:0]        deb_cnt_q;
    logic [2:0][DEB_W-1:0]        deb_cnt_d;
    logic [2:0]                   press_s;

    state_t                       state_q;
    state_t                       state_d;
    logic                         dir_up_q;
    logic                         dir_up_d;
    logic [CH_W-1:0]              ch_idx_q;
    logic [CH_W-1:0]              ch_idx_d;
    logic [NUM_CH-1:0]            chip_select_q;
    logic [NUM_CH-1:0][3:0]       shadow_q;
    logic [NUM_CH-1:0][3:0]       shadow_d;
    logic [3:0]                   duty_shadow_q;
    logic                         up_q;
    logic                         up_d;
    logic                         down_q;
    logic                         down_d;
    logic                         busy_q;
    logic                         issue_s;
    logic                         issue_up_s;
    logic [3:0]                   cur_shadow_s;

`ifdef AUTO_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
    logic [REP_W-1:0]             rep_q;
    logic [REP_W-1:0]             rep_d;
`endif

    assign raw_s = {btn_ch, btn_down, btn_up};

    // Two-flop synchronisers for the asynchronous buttons.
    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
        end else begin
            sync1_q <= raw_s;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: the stable level flips on the DEB_CYCLES-th consecutive differing sample.
    always_comb begin
        stable_d  = stable_q;
        deb_cnt_d = deb_cnt_q;
        for (int b = 0; b < 3; b++) begin
            if (sync2_q[b] == stable_q[b]) begin
                deb_cnt_d[b] = {DEB_W{1'b0}};
            end else if (deb_cnt_q[b] == DEB_W'(DEB_CYCLES - 1)) begin
                deb_cnt_d[b] = {DEB_W{1'b0}};
                stable_d[b]  = ~stable_q[b];
            end else begin
                deb_cnt_d[b] = deb_cnt_q[b] + DEB_W'(1);
            end
        end
    end

    // Debounce state and previous stable level for edge detection.
    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            stable_q      <= 3'b000;
            stable_prev_q <= 3'b000;
            deb_cnt_q     <= {3{{DEB_W{1'b0}}}};
        end else begin
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            deb_cnt_q     <= deb_cnt_d;
        end
    end

    assign press_s      = stable_q & ~stable_prev_q;
    assign cur_shadow_s = shadow_q[ch_idx_q];

    // Sequencer next state, channel selection and saturating shadow update.
    always_comb begin
        state_d    = state_q;
        dir_up_d   = dir_up_q;
        ch_idx_d   = ch_idx_q;
        shadow_d   = shadow_q;
        up_d       = 1'b0;
        down_d     = 1'b0;
        issue_s    = 1'b0;
        issue_up_s = dir_up_q;

        case (state_q)
            ST_IDLE: begin
                if (press_s[B_CH]) begin
                    // Channel advance wins; simultaneous up/down presses are dropped.
                    if (ch_idx_q == CH_W'(NUM_CH - 1)) begin
                        ch_idx_d = {CH_W{1'b0}};
                    end else begin
                        ch_idx_d = ch_idx_q + CH_W'(1);
                    end
                end else if (press_s[B_UP] ^ press_s[B_DN]) begin
                    state_d    = ST_ISSUE;
                    issue_s    = 1'b1;
                    issue_up_s = press_s[B_UP];
                    dir_up_d   = press_s[B_UP];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                // Release of the issuing button takes priority over a repeat.
                if (dir_up_q ? ~stable_q[B_UP] : ~stable_q[B_DN]) begin
                    state_d = ST_IDLE;
`ifdef AUTO_REPEAT_EN
                end else if (rep_q == REP_W'(REPEAT_CYCLES - 1)) begin
                    state_d = ST_ISSUE;
                    issue_s = 1'b1;
`endif
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The strobe and shadow change are registered on the same edge that enters ISSUE.
        if (issue_s) begin
            if (issue_up_s) begin
                if (cur_shadow_s < 4'(DUTY_MAX)) begin
                    shadow_d[ch_idx_q] = cur_shadow_s + 4'd1;
                    up_d               = 1'b1;
                end else begin
                    up_d = 1'b0;
                end
            end else begin
                if (cur_shadow_s > 4'(DUTY_MIN)) begin
                    shadow_d[ch_idx_q] = cur_shadow_s - 4'd1;
                    down_d             = 1'b1;
                end else begin
                    down_d = 1'b0;
                end
            end
        end else begin
            up_d   = 1'b0;
            down_d = 1'b0;
        end
    end

`ifdef AUTO_REPEAT_EN
    // Repeat interval counter: cleared on every issue, counts while not idle.
    always_comb begin
        rep_d = rep_q;
        if (issue_s) begin
            rep_d = {REP_W{1'b0}};
        end else if (state_q != ST_IDLE) begin
            rep_d = rep_q + REP_W'(1);
        end else begin
            rep_d = rep_q;
        end
    end

    // Repeat counter register.
    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            rep_q <= {REP_W{1'b0}};
        end else begin
            rep_q <= rep_d;
        end
    end
`endif

    // Sequencer state and registered outputs.
    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            dir_up_q      <= 1'b0;
            ch_idx_q      <= {CH_W{1'b0}};
            chip_select_q <= NUM_CH'(1);
            shadow_q      <= {NUM_CH{4'(DUTY_RST)}};
            duty_shadow_q <= 4'(DUTY_RST);
            up_q          <= 1'b0;
            down_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            dir_up_q      <= dir_up_d;
            ch_idx_q      <= ch_idx_d;
            chip_select_q <= NUM_CH'(1) << ch_idx_d;
            shadow_q      <= shadow_d;
            duty_shadow_q <= shadow_d[ch_idx_d];
            up_q          <= up_d;
            down_q        <= down_d;
            busy_q        <= (state_d != ST_IDLE);
        end
    end

    assign up          = up_q;
    assign down        = down_q;
    assign chip_select = chip_select_q;
    assign ch_idx      = ch_idx_q;
    assign duty_shadow = duty_shadow_q;
    assign busy        = busy_q;

endmodule
